// File: rtl/mips32r1_wb_pkg.sv
// Shared constants for the MIPS32r1 Wishbone arbiter: FSM encodings, bus widths,
// watchdog counter width and the default dead-bus read pattern.
package mips32r1_wb_pkg;

   localparam int unsigned ADR_W  = 32;
   localparam int unsigned DAT_W  = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned WDOG_W = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   localparam logic [DAT_W-1:0] DEAD_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips32r1_wb_watchdog.sv
// Bus watchdog: counts slave stall cycles and flags the cycle on which the
// stall budget runs out; a genuine ack in that same cycle wins.
module wb_watchdog
   import mips32r1_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic stb,
   input  logic ack,
   input  logic clear,
   output logic expire
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

   logic [WDOG_W-1:0] cnt;
   logic [WDOG_W-1:0] cnt_nxt;

   // An ack seen without a strobe is not a bus event, so it neither counts nor clears.
   always_comb begin
      cnt_nxt = cnt;
      expire  = stb & ~ack & (cnt == LAST);
      if (clear || (stb && ack) || expire) begin
         cnt_nxt = '0;
      end else if (stb) begin
         cnt_nxt = cnt + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/mips32r1_wb_arb.sv
// Two-master Wishbone arbiter (instruction and data bridges) onto one slave bus,
// with round-robin tie-break and a stall watchdog that terminates hung cycles.
module mips32r1_wb_arb
   import mips32r1_wb_pkg::*;
#(
   parameter int unsigned      TIMEOUT   = 255,
   parameter logic [DAT_W-1:0] DEAD_DATA = DEAD_DATA_DEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,

   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   output logic [DAT_W-1:0] m0_dat_o,
   input  logic             m0_we_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic             m0_stb_i,
   input  logic             m0_cyc_i,
   output logic             m0_ack_o,

   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   output logic [DAT_W-1:0] m1_dat_o,
   input  logic             m1_we_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic             m1_stb_i,
   input  logic             m1_cyc_i,
   output logic             m1_ack_o,

   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   output logic             s_we_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic             s_stb_o,
   output logic             s_cyc_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,

   output logic             timeout_o
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       last_gnt;
   logic       last_gnt_nxt;
   logic       wd_clear;
   logic       wd_expire;
   logic       ack_hit;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         last_gnt <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   // Grant decision; a grant always returns through IDLE before changing hands.
   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      wd_clear     = 1'b0;
      case (state)
         ST_IDLE: begin
            wd_clear = 1'b1;
            if (m0_cyc_i && m1_cyc_i) begin
               state_nxt    = last_gnt ? ST_GNT0 : ST_GNT1;
               last_gnt_nxt = ~last_gnt;
            end else if (m0_cyc_i) begin
               state_nxt    = ST_GNT0;
               last_gnt_nxt = 1'b0;
            end else if (m1_cyc_i) begin
               state_nxt    = ST_GNT1;
               last_gnt_nxt = 1'b1;
            end
         end
         ST_GNT0: begin
            if (!m0_cyc_i) begin
               state_nxt = ST_IDLE;
               wd_clear  = 1'b1;
            end
         end
         ST_GNT1: begin
            if (!m1_cyc_i) begin
               state_nxt = ST_IDLE;
               wd_clear  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            wd_clear  = 1'b1;
         end
      endcase
   end

   // Slave-side request mux.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      case (state)
         ST_GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
         end
         ST_GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
         end
         default: ;
      endcase
   end

   assign ack_hit = s_ack_i & s_stb_o;

   wb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .stb    (s_stb_o),
      .ack    (s_ack_i),
      .clear  (wd_clear),
      .expire (wd_expire)
   );

   // Master-side response demux; an expired cycle is closed with the dead pattern.
   always_comb begin
      m0_ack_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_dat_o = '0;
      case (state)
         ST_GNT0: begin
            m0_ack_o = ack_hit | wd_expire;
            m0_dat_o = wd_expire ? DEAD_DATA : s_dat_i;
         end
         ST_GNT1: begin
            m1_ack_o = ack_hit | wd_expire;
            m1_dat_o = wd_expire ? DEAD_DATA : s_dat_i;
         end
         default: ;
      endcase
   end

   assign timeout_o = wd_expire;

endmodule

// File: tb/tb_mips32r1_wb_arb.sv
// Directed bench for mips32r1_wb_arb with a short watchdog budget (TIMEOUT = 8).
module tb_mips32r1_wb_arb;

   localparam int unsigned TMO = 8;
   localparam logic [31:0] A0  = 32'h0000_0010;
   localparam logic [31:0] A1  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
   logic        m0_we, m0_stb, m0_cyc, m0_ack, m1_we, m1_stb, m1_cyc, m1_ack;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic [31:0] s_adr, s_dat_w, s_dat_r;
   logic        s_we, s_stb, s_cyc, s_ack, tmo;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   mips32r1_wb_arb #(.TIMEOUT(TMO), .DEAD_DATA(32'hDEAD_BEEF)) dut (
      .wb_clk_i (clk),      .wb_rst_i (rst),
      .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat_w), .m0_dat_o (m0_dat_r),
      .m0_we_i  (m0_we),    .m0_sel_i (m0_sel),   .m0_stb_i (m0_stb),
      .m0_cyc_i (m0_cyc),   .m0_ack_o (m0_ack),
      .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat_w), .m1_dat_o (m1_dat_r),
      .m1_we_i  (m1_we),    .m1_sel_i (m1_sel),   .m1_stb_i (m1_stb),
      .m1_cyc_i (m1_cyc),   .m1_ack_o (m1_ack),
      .s_adr_o  (s_adr),    .s_dat_o  (s_dat_w),  .s_we_o   (s_we),
      .s_sel_o  (s_sel),    .s_stb_o  (s_stb),    .s_cyc_o  (s_cyc),
      .s_dat_i  (s_dat_r),  .s_ack_i  (s_ack),    .timeout_o(tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req0(input logic on);
      m0_cyc = on;
      m0_stb = on;
   endtask

   task automatic req1(input logic on);
      m1_cyc = on;
      m1_stb = on;
   endtask

   initial begin
      int w;
      int exp_m;
      rst = 1'b1;
      m0_adr = A0; m0_dat_w = 32'h0; m0_we = 1'b0; m0_sel = 4'hF;
      m1_adr = A1; m1_dat_w = 32'hCAFE_F00D; m1_we = 1'b1; m1_sel = 4'b0011;
      req0(1'b0); req1(1'b0);
      s_dat_r = 32'h0; s_ack = 1'b0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_s_cyc", 32'(s_cyc), 32'd0);
      chk("rst_s_adr", s_adr, 32'd0);
      chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      chk("rst_tmo", 32'(tmo), 32'd0);

      // m0 read alone: one-cycle arbitration, slave acks on third stalled cycle
      req0(1'b1);
      #1 chk("m0_lat_idle", 32'(s_cyc), 32'd0);
      step();
      chk("m0_gnt_cyc", 32'(s_cyc), 32'd1);
      chk("m0_gnt_adr", s_adr, A0);
      chk("m0_noack", 32'(m0_ack), 32'd0);
      step(); step();
      s_ack = 1'b1; s_dat_r = 32'h1234_5678;
      #1;
      chk("m0_ack", 32'(m0_ack), 32'd1);
      chk("m0_dat", m0_dat_r, 32'h1234_5678);
      chk("m0_m1ack", 32'(m1_ack), 32'd0);
      step();
      s_ack = 1'b0; req0(1'b0);
      step();

      // Tie from reset goes to m1; m1 write payload passes through
      rst = 1'b1; step(); rst = 1'b0;
      req0(1'b1); req1(1'b1);
      step();
      chk("tie_adr", s_adr, A1);
      chk("m1_sel", 32'(s_sel), 32'h3);
      chk("m1_dat", s_dat_w, 32'hCAFE_F00D);
      chk("m1_we", 32'(s_we), 32'd1);
      s_ack = 1'b1;
      #1;
      chk("m1_ack", 32'(m1_ack), 32'd1);
      chk("m0_held", 32'(m0_ack), 32'd0);
      step();
      s_ack = 1'b0; req1(1'b0);
      #1 chk("m0_held2", 32'(m0_ack), 32'd0);
      step();
      chk("bubble_cyc", 32'(s_cyc), 32'd0);
      step();
      chk("m0_after", s_adr, A0);
      chk("m0_after_cyc", 32'(s_cyc), 32'd1);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0; req0(1'b0);
      step();

      // Continuous contention: last grant was m0, so m1,m0,m1,m0
      req0(1'b1); req1(1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_m = (i % 2 == 0) ? 1 : 0;
         #1;
         w = 0;
         while (!s_cyc && w < 5) begin
            step();
            w++;
         end
         chk("alt_cyc", 32'(s_cyc), 32'd1);
         chk("alt_who", s_adr, (exp_m == 1) ? A1 : A0);
         s_ack = 1'b1;
         #1 chk("alt_ack", {30'd0, m1_ack, m0_ack}, (exp_m == 1) ? 32'd2 : 32'd1);
         step();
         s_ack = 1'b0;
         if (exp_m == 1) req1(1'b0); else req0(1'b0);
         step();
         if (exp_m == 1) req1(1'b1); else req0(1'b1);
      end
      req0(1'b0); req1(1'b0);
      step(); step();

      // Hung slave: watchdog closes the cycle on the 8th stalled cycle
      req0(1'b1);
      step();
      for (int n = 1; n <= 8; n++) begin
         chk("wd_tmo", 32'(tmo), (n == 8) ? 32'd1 : 32'd0);
         chk("wd_ack", 32'(m0_ack), (n == 8) ? 32'd1 : 32'd0);
         if (n == 8) chk("wd_dat", m0_dat_r, 32'hDEAD_BEEF);
         if (n < 8) step();
      end
      step();
      req0(1'b0); s_ack = 1'b1;
      #1 chk("late_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      step();
      chk("late_ack_idle", {29'd0, tmo, m1_ack, m0_ack}, 32'd0);
      s_ack = 1'b0;
      step();

      // Ack arriving on the expiry cycle is a real ack
      req0(1'b1);
      step();
      for (int n = 0; n < 7; n++) step();
      s_ack = 1'b1; s_dat_r = 32'h0000_A5A5;
      #1;
      chk("race_dat", m0_dat_r, 32'h0000_A5A5);
      chk("race_tmo", 32'(tmo), 32'd0);
      chk("race_ack", 32'(m0_ack), 32'd1);
      step();
      s_ack = 1'b0; req0(1'b0);
      step(); step();

      // Reset mid-GNT0 with strobe high, then m1 wins the tie
      req0(1'b1);
      step();
      chk("pre_rst_cyc", 32'(s_cyc), 32'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_bus", {28'd0, s_cyc, s_stb, s_we, tmo}, 32'd0);
      chk("mid_rst_adr", s_adr, 32'd0);
      chk("mid_rst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      rst = 1'b0; req1(1'b1);
      step();
      chk("post_rst_win", s_adr, A1);
      req0(1'b0); req1(1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mips32r1_wb_arb.md
MIPS32R1_WB_ARB -- requirements
Module: mips32r1_wb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: slave-stall cycles before the bus watchdog fires; legal range 1..1023.
REQ-002 SHALL have parameter DEAD_DATA, default 32'hDEADBEEF: read data returned on a watchdog-terminated cycle.
REQ-003 SHALL have port wb_clk_i, input, 1: single clock.
REQ-004 SHALL have port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports m0_adr_i/m1_adr_i, input, 32: master address (m0 = instruction bridge, m1 = data bridge).
REQ-006 SHALL have ports m0_dat_i/m1_dat_i, input, 32: master write data.
REQ-007 SHALL have ports m0_dat_o/m1_dat_o, output, 32: read data to master.
REQ-008 SHALL have ports m0_we_i/m1_we_i, input, 1: write enable.
REQ-009 SHALL have ports m0_sel_i/m1_sel_i, input, 4: byte selects.
REQ-010 SHALL have ports m0_stb_i/m1_stb_i and m0_cyc_i/m1_cyc_i, input, 1 each: strobe and cycle.
REQ-011 SHALL have ports m0_ack_o/m1_ack_o, output, 1: acknowledge to master.
REQ-012 SHALL have ports s_adr_o (32), s_dat_o (32), s_we_o (1), s_sel_o (4), s_stb_o (1), s_cyc_o (1), output: shared slave bus.
REQ-013 SHALL have ports s_dat_i (32) and s_ack_i (1), input: slave read data and acknowledge.
REQ-014 SHALL have port timeout_o, output, 1: one-cycle pulse when the watchdog terminates a cycle.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, GNT0, GNT1.
REQ-016 IDLE, only mN_cyc_i high -> GNTN on the next edge.
REQ-017 IDLE, both cyc high -> grant the master not recorded in the last-grant register.
REQ-018 SHALL update the last-grant register on every IDLE->GNTx transition; its reset value is 0, so m1 wins the first tie.
REQ-019 While in GNTx, s_adr_o/s_dat_o/s_we_o/s_sel_o/s_stb_o/s_cyc_o SHALL equal master x's inputs combinationally.
REQ-020 In IDLE, all s_* outputs SHALL be 0.
REQ-021 Arbitration latency SHALL be exactly one cycle from cyc rising in IDLE to s_cyc_o rising.
REQ-022 mx_ack_o SHALL equal s_ack_i & s_stb_o combinationally in GNTx; the non-granted master's ack SHALL be 0.
REQ-023 mx_dat_o SHALL equal s_dat_i in GNTx; otherwise 0.
REQ-024 GNTx with mx_cyc_i low -> IDLE on the next edge; grant SHALL NOT transfer directly GNT0<->GNT1 (one IDLE bubble minimum).
REQ-025 The other master's requests during GNTx SHALL be held off with no ack; no request SHALL be lost while its cyc stays high.
REQ-026 Watchdog: a 10-bit counter SHALL increment each cycle s_stb_o=1 and s_ack_i=0.
REQ-027 The watchdog counter SHALL clear on ack, on leaving GNTx, or on reaching TIMEOUT.
REQ-028 When the counter equals TIMEOUT-1 with no ack, mx_ack_o=1 and mx_dat_o=DEAD_DATA SHALL be asserted for that cycle, with timeout_o=1.
REQ-029 The slave's late ack after a timeout SHALL be ignored once the state has left GNTx.
REQ-030 s_ack_i in the same cycle as timeout expiry SHALL be treated as a genuine ack: slave data returned, timeout_o=0.
REQ-031 s_ack_i while s_stb_o=0 SHALL be ignored and SHALL NOT clear the counter.

Reset
REQ-032 wb_rst_i high at any edge SHALL force IDLE, last-grant=0, counter=0, timeout_o=0, all acks and s_* outputs 0, including mid-cycle.
REQ-033 After reset deasserts, arbitration SHALL resume with the first edge on which any cyc is high.

Structure
REQ-034 FSM state encodings, counter width (10) and DEAD_DATA default SHALL live in shared package mips32r1_wb_pkg.
REQ-035 The watchdog SHALL be sub-module wb_watchdog (inputs: clk, rst, stb, ack, clear; output: expire).
REQ-036 The FSM and datapath mux SHALL remain in mips32r1_wb_arb.

Verification
REQ-037 m0 read alone, slave acks 2 cycles after stb -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_dat_o = s_dat_i (e.g. 32'h1234_5678) with m0_ack_o; m1_ack_o=0.
REQ-038 Both request from reset -> m1 granted first; after m1 drops cyc, IDLE bubble, then m0 granted.
REQ-039 Both request continuously for 4 transactions -> grants strictly alternate m1,m0,m1,m0.
REQ-040 m1 write to 32'h0000_0100, sel=4'b0011, dat=32'hCAFE_F00D -> identical s_adr_o/s_sel_o/s_dat_o/s_we_o=1 while granted.
REQ-041 Slave never acks, TIMEOUT=8 -> ack with 32'hDEADBEEF and timeout_o pulse 8 cycles after s_stb_o rises; a later s_ack_i produces no master ack.
REQ-042 wb_rst_i asserted mid-GNT0 with stb high -> next edge all outputs 0; then m1 request wins the next grant.
